rect_fill: RTL and testbench

//   Parametrised frame-buffer fill engine, successor to the full-screen clear block.
//   - Rasters any clipped rectangle (x0,y0)-(x1,y1) with one colour, X fastest, then Y.
//   - Each pixel is offered on a valid/ready write port, so the frame-buffer

---
 rtl/rect_fill_pkg.sv | 9 +
 rtl/rect_fill_if.sv | 14 +
 rtl/rect_fill_raster_scan.sv | 52 +++++
 rtl/rect_fill.sv | 102 ++++++++++
 tb/tb_rect_fill.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/rect_fill_pkg.sv
// rect_fill_pkg: shared state encoding and default geometry for the rectangle fill engine.
package rect_fill_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
  localparam int DEF_X_W = 8;
  localparam int DEF_Y_W = 8;
  localparam int DEF_COLOR_W = 3;
  localparam int DEF_MAX_X = 159;
  localparam int DEF_MAX_Y = 119;
endpackage

// File: rtl/rect_fill_if.sv
// rect_fill_if: valid/ready pixel write port between the fill engine and the frame-buffer arbiter.
interface rect_fill_if #(
  parameter int X_W = rect_fill_pkg::DEF_X_W,
  parameter int Y_W = rect_fill_pkg::DEF_Y_W,
  parameter int COLOR_W = rect_fill_pkg::DEF_COLOR_W
);
  logic plot;
  logic plot_ready;
  logic [X_W-1:0] CounterX;
  logic [Y_W-1:0] CounterY;
  logic [COLOR_W-1:0] color_out;
  modport master (output plot, CounterX, CounterY, color_out, input plot_ready);
  modport slave (input plot, CounterX, CounterY, color_out, output plot_ready);
endinterface

// File: rtl/rect_fill_raster_scan.sv
// raster_scan: X-fastest X/Y counters over a loaded [xmin..xmax] x [ymin..ymax] window.
module raster_scan #(
  parameter int X_W = 8,
  parameter int Y_W = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           load,
  input  logic           advance,
  input  logic [X_W-1:0] xmin,
  input  logic [X_W-1:0] xmax,
  input  logic [Y_W-1:0] ymin,
  input  logic [Y_W-1:0] ymax,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           last
);
  logic [X_W-1:0] x_q, x_d, xmin_q, xmin_d, xmax_q, xmax_d;
  logic [Y_W-1:0] y_q, y_d, ymin_q, ymin_d, ymax_q, ymax_d;
  logic row_end, step;
  always_comb begin
    row_end = x_q == xmax_q;
    last = row_end && y_q == ymax_q;
    // the final beat holds the counters so they never pass xmax/ymax
    step = advance && !last;
    xmin_d = load ? xmin : xmin_q;
    xmax_d = load ? xmax : xmax_q;
    ymin_d = load ? ymin : ymin_q;
    ymax_d = load ? ymax : ymax_q;
    x_d = load ? xmin : !step ? x_q : row_end ? xmin_q : x_q + 1'b1;
    y_d = load ? ymin : (step && row_end) ? y_q + 1'b1 : y_q;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_q <= '0;
      y_q <= '0;
      xmin_q <= '0;
      xmax_q <= '0;
      ymin_q <= '0;
      ymax_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
      xmin_q <= xmin_d;
      xmax_q <= xmax_d;
      ymin_q <= ymin_d;
      ymax_q <= ymax_d;
    end
  end
  assign x = x_q;
  assign y = y_q;
endmodule

// File: rtl/rect_fill.sv
// rect_fill: clipped rectangle fill engine streaming pixels over a valid/ready port.
// RECT_FILL_CHECKER_EN selects a checkerboard of color/color_alt instead of a flat colour.
module rect_fill
  import rect_fill_pkg::*;
#(
  parameter int X_W = DEF_X_W,
  parameter int Y_W = DEF_Y_W,
  parameter int COLOR_W = DEF_COLOR_W,
  parameter int MAX_X = DEF_MAX_X,
  parameter int MAX_Y = DEF_MAX_Y
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [X_W-1:0]     x0,
  input  logic [X_W-1:0]     x1,
  input  logic [Y_W-1:0]     y0,
  input  logic [Y_W-1:0]     y1,
  input  logic [COLOR_W-1:0] color,
  input  logic [COLOR_W-1:0] color_alt,
  rect_fill_if.master        pix,
  output logic               busy,
  output logic               finished
);
  localparam logic [X_W-1:0] MX = X_W'(MAX_X);
  localparam logic [Y_W-1:0] MY = Y_W'(MAX_Y);
  state_t state_q, state_d;
  logic [X_W-1:0] x0_q, x0_d, x1_q, x1_d, xmin, xhi, xmax, cx;
  logic [Y_W-1:0] y0_q, y0_d, y1_q, y1_d, ymin, yhi, ymax, cy;
  logic [COLOR_W-1:0] color_q, color_d;
  logic take, empty, accept, last;
  always_comb begin
    take = state_q == IDLE && start;
    x0_d = take ? x0 : x0_q;
    x1_d = take ? x1 : x1_q;
    y0_d = take ? y0 : y0_q;
    y1_d = take ? y1 : y1_q;
    color_d = take ? color : color_q;
    xmin = x0_q < x1_q ? x0_q : x1_q;
    xhi = x0_q < x1_q ? x1_q : x0_q;
    xmax = xhi > MX ? MX : xhi;
    ymin = y0_q < y1_q ? y0_q : y1_q;
    yhi = y0_q < y1_q ? y1_q : y0_q;
    ymax = yhi > MY ? MY : yhi;
    empty = xmin > MX || ymin > MY;
    accept = pix.plot && pix.plot_ready;
    // abort beats a simultaneous final acceptance
    state_d = state_q == IDLE ? (start ? LOAD : IDLE)
            : state_q == LOAD ? (abort ? IDLE : empty ? DONE : RUN)
            : state_q == RUN  ? (abort ? IDLE : (accept && last) ? DONE : RUN)
            : IDLE;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      x0_q <= '0;
      x1_q <= '0;
      y0_q <= '0;
      y1_q <= '0;
      color_q <= '0;
    end else begin
      state_q <= state_d;
      x0_q <= x0_d;
      x1_q <= x1_d;
      y0_q <= y0_d;
      y1_q <= y1_d;
      color_q <= color_d;
    end
  end
  raster_scan #(.X_W(X_W), .Y_W(Y_W)) u_scan (
    .clk(clk),
    .reset(reset),
    .load(state_q == LOAD),
    .advance(accept && !abort),
    .xmin(xmin),
    .xmax(xmax),
    .ymin(ymin),
    .ymax(ymax),
    .x(cx),
    .y(cy),
    .last(last)
  );
  assign pix.plot = state_q == RUN;
  assign pix.CounterX = cx;
  assign pix.CounterY = cy;
  assign busy = state_q == LOAD || state_q == RUN;
  assign finished = state_q == DONE;
`ifdef RECT_FILL_CHECKER_EN
  logic [COLOR_W-1:0] alt_q, alt_d;
  always_comb alt_d = take ? color_alt : alt_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) alt_q <= '0;
    else alt_q <= alt_d;
  end
  assign pix.color_out = (cx[0] ^ cy[0]) ? alt_q : color_q;
`else
  logic unused_alt;
  assign unused_alt = ^color_alt;
  assign pix.color_out = color_q;
`endif
endmodule

// File: tb/tb_rect_fill.sv
// tb_rect_fill: directed self-checking bench for rect_fill.
module tb_rect_fill;
`ifdef RECT_FILL_CHECKER_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  logic clk = 0, reset = 0, start = 0, abort = 0;
  logic [7:0] x0 = 0, x1 = 0, y0 = 0, y1 = 0;
  logic [2:0] color = 0, color_alt = 0, cur_col = 0, cur_alt = 0;
  logic busy, finished;
  int checks = 0, errors = 0;

  rect_fill_if bus ();
  rect_fill dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .x0(x0), .x1(x1), .y0(y0), .y1(y1),
    .color(color), .color_alt(color_alt),
    .pix(bus), .busy(busy), .finished(finished)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] expcol(input int x, input int y);
    return (CHK && ((x ^ y) & 1) != 0) ? cur_alt : cur_col;
  endfunction

  task automatic kick(input int ax0, input int ay0, input int ax1, input int ay1,
                      input logic [2:0] c, input logic [2:0] a);
    @(posedge clk); #1;
    x0 = 8'(ax0); y0 = 8'(ay0); x1 = 8'(ax1); y1 = 8'(ay1);
    color = c; color_alt = a; cur_col = c; cur_alt = a;
    start = 1;
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic run_fill(input int nb, input int xl, input int xh, input int yl, input int yh,
                          input int fin, input string nm, input bit inj);
    int cnt = 0, beats = 0, oerr = 0, ex = xl, ey = yl;
    bit done = 0;
    bus.plot_ready = 1;
    while (!done && cnt < 25000) begin
      @(negedge clk); cnt++;
      if (inj && cnt == 1) begin
        start = 1; x0 = 50; y0 = 50; x1 = 50; y1 = 50; color = 0; color_alt = 0;
      end else if (inj && cnt == 3) start = 0;
      if (bus.plot) begin
        if (bus.CounterX !== 8'(ex) || bus.CounterY !== 8'(ey) || bus.color_out !== expcol(ex, ey)) oerr++;
        beats++;
        if (ex == xh) begin ex = xl; ey++; end else ex++;
      end
      if (finished) done = 1;
    end
    checks++; if (!done || cnt != fin) begin errors++; $display("FAIL %s finish cycle: got %0d expected %0d", nm, cnt, fin); end
    checks++; if (beats != nb) begin errors++; $display("FAIL %s beats: got %0d expected %0d", nm, beats, nb); end
    checks++; if (oerr != 0) begin errors++; $display("FAIL %s raster order/colour: got %0d bad beats expected 0", nm, oerr); end
    @(negedge clk);
    checks++; if ({finished, busy, bus.plot} !== 3'b000) begin errors++; $display("FAIL %s after done: got %b expected 000", nm, {finished, busy, bus.plot}); end
  endtask

  task automatic test_reset;
    bus.plot_ready = 1;
    #12;
    checks++; if ({bus.plot, busy, finished} !== 3'b000) begin errors++; $display("FAIL reset flags: got %b expected 000", {bus.plot, busy, finished}); end
    checks++; if ({bus.CounterX, bus.CounterY, bus.color_out} !== 19'd0) begin errors++; $display("FAIL reset data: got %h expected 0", {bus.CounterX, bus.CounterY, bus.color_out}); end
    @(negedge clk); reset = 1;
  endtask

  task automatic test_full_clear;
    kick(0, 0, 159, 119, 5, 2);
    run_fill(19200, 0, 159, 0, 119, 19202, "full_clear", 0);
  endtask

  task automatic test_reversed_clip;
    kick(200, 5, 150, 6, 3, 4);
    run_fill(20, 150, 159, 5, 6, 22, "reversed_clip", 0);
  endtask

  task automatic test_backpressure;
    int herr = 0;
    bus.plot_ready = 0;
    kick(3, 3, 4, 3, 6, 1);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1 && bus.plot !== 1'b0) herr++;
      if (c >= 2 && !(bus.plot === 1'b1 && bus.CounterX === 8'd3 && bus.CounterY === 8'd3 && bus.color_out === expcol(3, 3))) herr++;
    end
    checks++; if (herr != 0) begin errors++; $display("FAIL backpressure hold: got %0d bad cycles expected 0", herr); end
    bus.plot_ready = 1;
    @(negedge clk);
    checks++; if (!(bus.plot === 1'b1 && bus.CounterX === 8'd4 && bus.CounterY === 8'd3 && bus.color_out === expcol(4, 3)))
      begin errors++; $display("FAIL backpressure second beat: got plot=%b x=%0d y=%0d c=%0d expected 1 4 3 %0d", bus.plot, bus.CounterX, bus.CounterY, bus.color_out, expcol(4, 3)); end
    @(negedge clk);
    checks++; if ({finished, bus.plot} !== 2'b10) begin errors++; $display("FAIL backpressure finish: got %b expected 10", {finished, bus.plot}); end
    @(negedge clk);
  endtask

  task automatic test_abort;
    int fcnt = 0;
    kick(0, 0, 9, 9, 2, 5);
    repeat (6) @(negedge clk);
    checks++; if (!(bus.plot === 1'b1 && bus.CounterX === 8'd4 && bus.CounterY === 8'd0))
      begin errors++; $display("FAIL abort 5th beat: got plot=%b x=%0d y=%0d expected 1 4 0", bus.plot, bus.CounterX, bus.CounterY); end
    abort = 1;
    @(negedge clk); abort = 0;
    checks++; if ({bus.plot, busy, finished} !== 3'b000) begin errors++; $display("FAIL abort idle: got %b expected 000", {bus.plot, busy, finished}); end
    repeat (3) begin @(negedge clk); if (finished !== 1'b0 || bus.plot !== 1'b0) fcnt++; end
    checks++; if (fcnt != 0) begin errors++; $display("FAIL abort quiet: got %0d active cycles expected 0", fcnt); end
    kick(0, 0, 9, 9, 2, 5);
    run_fill(100, 0, 9, 0, 9, 102, "abort_restart", 0);
    kick(7, 7, 7, 7, 1, 1);
    repeat (2) @(negedge clk);
    abort = 1;
    @(negedge clk); abort = 0;
    checks++; if ({finished, busy, bus.plot} !== 3'b000) begin errors++; $display("FAIL abort final beat: got %b expected 000", {finished, busy, bus.plot}); end
    @(negedge clk);
    checks++; if (finished !== 1'b0) begin errors++; $display("FAIL abort final no finish: got %b expected 0", finished); end
  endtask

  task automatic test_edges;
    kick(170, 0, 180, 10, 1, 2);
    run_fill(0, 0, 0, 0, 0, 2, "empty", 0);
    kick(7, 7, 7, 7, 4, 3);
    run_fill(1, 7, 7, 7, 7, 3, "single", 0);
    kick(0, 0, 3, 0, 7, 0);
    run_fill(4, 0, 3, 0, 0, 6, "start_busy", 1);
  endtask

  task automatic test_color;
    kick(0, 0, 1, 1, 1, 6);
    run_fill(4, 0, 1, 0, 1, 6, "color", 0);
  endtask

  task automatic test_reset_mid_run;
    int act = 0;
    kick(0, 0, 9, 9, 5, 5);
    repeat (4) @(negedge clk);
    checks++; if (bus.plot !== 1'b1) begin errors++; $display("FAIL mid-run plot before reset: got %b expected 1", bus.plot); end
    reset = 0; #1;
    checks++; if ({bus.plot, busy, finished} !== 3'b000) begin errors++; $display("FAIL mid-run reset flags: got %b expected 000", {bus.plot, busy, finished}); end
    checks++; if ({bus.CounterX, bus.CounterY, bus.color_out} !== 19'd0) begin errors++; $display("FAIL mid-run reset data: got %h expected 0", {bus.CounterX, bus.CounterY, bus.color_out}); end
    @(negedge clk); reset = 1;
    repeat (3) begin @(negedge clk); if (bus.plot !== 1'b0 || busy !== 1'b0) act++; end
    checks++; if (act != 0) begin errors++; $display("FAIL mid-run no resume: got %0d active cycles expected 0", act); end
  endtask

  initial begin
    test_reset;
    test_full_clear;
    test_reversed_clip;
    test_backpressure;
    test_abort;
    test_edges;
    test_color;
    test_reset_mid_run;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
